// File: rtl/lc3b_types_pkg.sv
// Shared LC-3b pipeline types used by the EXE forwarding controller:
// the per-stage shadow record, the controller FSM state, the forward
// source encodings and the debug view of the controller.
package lc3b_types;

    // Forward source encodings for opA_src / opB_src.
    localparam logic FWD_MEM = 1'b0;
    localparam logic FWD_WB  = 1'b1;

    // What the controller remembers about the instruction in a stage.
    typedef struct packed {
        logic       valid;
        logic [2:0] dest;
        logic       regwrite;
        logic       is_load;
    } fwd_rec_t;

    // RUN     : normal flow, hazards are evaluated every cycle.
    // LDUSE   : the previous cycle inserted a load-use (or MEM-match) bubble.
    // MEMWAIT : the MEM stage is waiting for mem_resp.
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDUSE   = 2'd1,
        ST_MEMWAIT = 2'd2
    } fwd_state_t;

    // Debug view: FSM state plus the three shadow records.
    typedef struct packed {
        fwd_state_t state;
        fwd_rec_t   ex_rec;
        fwd_rec_t   mem_rec;
        fwd_rec_t   wb_rec;
    } fwd_dbg_t;

endpackage

// File: rtl/exe_fwd_ctrl_fwd_match.sv
// fwd_match: comparator and priority logic for one EXE operand.
// The decode source is compared against the producers that will sit in
// MEM (today's EX record) and WB (today's MEM record) when the decode
// instruction reaches EX. The youngest producer wins.
// Build option EXE_WB_FWD_EN: when defined, a MEM-record match forwards
// from WB; otherwise it is reported as mem_hazard so the top can bubble.
module fwd_match
    import lc3b_types::*;
(
    input  logic       src_used,     // decode valid and this source is read
    input  logic [2:0] src_reg,
    input  fwd_rec_t   ex_rec,
    input  logic       mem_valid,
    input  logic       mem_regwrite,
    input  logic [2:0] mem_dest,
    output logic       fwd_sel,
    output logic       fwd_src,
    output logic       load_use,     // EX-record load feeds this source
    output logic       mem_hazard    // MEM-record match that cannot forward
);

    logic ex_hit;
    logic mem_hit;

    // Producer matches; R0 is compared like any other register.
    always_comb begin
        ex_hit  = src_used && ex_rec.valid && ex_rec.regwrite
                  && (ex_rec.dest == src_reg);
        mem_hit = src_used && mem_valid && mem_regwrite
                  && (mem_dest == src_reg);
    end

    // Youngest-first selection of the forward source.
    always_comb begin
        fwd_sel    = 1'b0;
        fwd_src    = FWD_MEM;
        mem_hazard = 1'b0;
        load_use   = ex_hit && ex_rec.is_load;
        if (ex_hit) begin
            fwd_sel = 1'b1;
            fwd_src = FWD_MEM;
        end else if (mem_hit) begin
`ifdef EXE_WB_FWD_EN
            fwd_sel = 1'b1;
            fwd_src = FWD_WB;
`else
            mem_hazard = 1'b1;
`endif
        end
    end

endmodule

// File: rtl/exe_fwd_ctrl.sv
// exe_fwd_ctrl: EXE operand forwarding and hazard controller for the
// LC-3b pipeline. Keeps shadow records of the EX/MEM/WB instructions,
// registers the operand mux selects one cycle ahead of use, and drives
// stall/bubble for load-use hazards and memory waits.
// Build option EXE_WB_FWD_EN enables forwarding from WB; without it a
// match against the MEM record costs one bubble instead.
//
// stall/bubble handshake: stall and bubble are combinational for the
// current cycle and take effect at the coming clock edge. stall=1 holds
// fetch/decode/EX; bubble=1 (always with stall=1) lets MEM and WB advance
// while EX loads a NOP. The decode fields must stay stable while stall=1.
module exe_fwd_ctrl
    import lc3b_types::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [2:0] id_sr1,
    input  logic [2:0] id_sr2,
    input  logic       id_use_sr1,
    input  logic       id_use_sr2,
    input  logic [2:0] id_dest,
    input  logic       id_regwrite,
    input  logic       id_is_load,
    input  logic       mem_resp,
    input  logic       mem_busy,
    output logic       opA_sel,
    output logic       opB_sel,
    output logic       opA_src,
    output logic       opB_src,
    output logic       stall,
    output logic       bubble,
    output fwd_dbg_t   dbg
);

    fwd_state_t state;
    fwd_state_t state_next;

    fwd_rec_t dec_rec;
    fwd_rec_t ex_rec;
    fwd_rec_t mem_rec;
    fwd_rec_t wb_rec;

    logic a_sel, a_src, a_load_use, a_mem_hazard;
    logic b_sel, b_src, b_load_use, b_mem_hazard;
    logic load_use;
    logic mem_hazard;
    logic mem_wait;

    // Record describing the instruction currently in decode.
    always_comb begin
        dec_rec          = '0;
        dec_rec.valid    = id_valid;
        dec_rec.dest     = id_dest;
        dec_rec.regwrite = id_regwrite;
        dec_rec.is_load  = id_is_load;
    end

    fwd_match u_match_a (
        .src_used     (id_valid && id_use_sr1),
        .src_reg      (id_sr1),
        .ex_rec       (ex_rec),
        .mem_valid    (mem_rec.valid),
        .mem_regwrite (mem_rec.regwrite),
        .mem_dest     (mem_rec.dest),
        .fwd_sel      (a_sel),
        .fwd_src      (a_src),
        .load_use     (a_load_use),
        .mem_hazard   (a_mem_hazard)
    );

    fwd_match u_match_b (
        .src_used     (id_valid && id_use_sr2),
        .src_reg      (id_sr2),
        .ex_rec       (ex_rec),
        .mem_valid    (mem_rec.valid),
        .mem_regwrite (mem_rec.regwrite),
        .mem_dest     (mem_rec.dest),
        .fwd_sel      (b_sel),
        .fwd_src      (b_src),
        .load_use     (b_load_use),
        .mem_hazard   (b_mem_hazard)
    );

    // Either operand can raise a hazard.
    always_comb begin
        load_use   = a_load_use || b_load_use;
        mem_hazard = a_mem_hazard || b_mem_hazard;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state and stall/bubble. A memory wait beats a data hazard;
    // the hazard is looked at again in the cycle the response arrives, so
    // a pending load-use still gets its single bubble then.
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        bubble     = 1'b0;
        mem_wait   = 1'b0;
        case (state)
            ST_MEMWAIT: mem_wait = !mem_resp;
            default:    mem_wait = mem_busy && !mem_resp;
        endcase
        if (mem_wait) begin
            stall      = 1'b1;
            state_next = ST_MEMWAIT;
        end else if (load_use || mem_hazard) begin
            stall      = 1'b1;
            bubble     = 1'b1;
            state_next = ST_LDUSE;
        end else begin
            state_next = ST_RUN;
        end
    end

    // Shadow records: advance when not stalled; on a bubble MEM/WB still
    // advance and EX takes an invalid record; a plain stall holds all.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_rec  <= '0;
            mem_rec <= '0;
            wb_rec  <= '0;
        end else if (!stall) begin
            ex_rec  <= dec_rec;
            mem_rec <= ex_rec;
            wb_rec  <= mem_rec;
        end else if (bubble) begin
            ex_rec  <= '0;
            mem_rec <= ex_rec;
            wb_rec  <= mem_rec;
        end
    end

    // Registered operand selects for the instruction entering EX. They
    // hold through a memory wait and clear when EX receives a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            opA_sel <= 1'b0;
            opA_src <= FWD_MEM;
            opB_sel <= 1'b0;
            opB_src <= FWD_MEM;
        end else if (bubble) begin
            opA_sel <= 1'b0;
            opA_src <= FWD_MEM;
            opB_sel <= 1'b0;
            opB_src <= FWD_MEM;
        end else if (!stall) begin
            opA_sel <= a_sel;
            opA_src <= a_src;
            opB_sel <= b_sel;
            opB_src <= b_src;
        end
    end

    // Debug view of the controller.
    always_comb begin
        dbg         = '0;
        dbg.state   = state;
        dbg.ex_rec  = ex_rec;
        dbg.mem_rec = mem_rec;
        dbg.wb_rec  = wb_rec;
    end

`ifndef SYNTHESIS
    logic [7:0] wait_cnt;

    // Saturating count of cycles spent in MEMWAIT, cleared on entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state != ST_MEMWAIT && state_next == ST_MEMWAIT) begin
            wait_cnt <= '0;
        end else if (state == ST_MEMWAIT && wait_cnt != 8'hFF) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_exe_fwd_ctrl.sv
// Directed bench for exe_fwd_ctrl. Inputs change 1 ns after the rising
// edge, outputs are checked 1 ns later. Expectations for the WB-forwarding
// build are selected with EXE_WB_FWD_EN.
module tb_exe_fwd_ctrl;
    import lc3b_types::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [2:0] id_sr1;
    logic [2:0] id_sr2;
    logic       id_use_sr1;
    logic       id_use_sr2;
    logic [2:0] id_dest;
    logic       id_regwrite;
    logic       id_is_load;
    logic       mem_resp;
    logic       mem_busy;
    logic       opA_sel;
    logic       opB_sel;
    logic       opA_src;
    logic       opB_src;
    logic       stall;
    logic       bubble;
    fwd_dbg_t   dbg;

    int checks = 0;
    int errors = 0;

    // Clock.
    always #5 clk = ~clk;

    exe_fwd_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_sr1      (id_sr1),
        .id_sr2      (id_sr2),
        .id_use_sr1  (id_use_sr1),
        .id_use_sr2  (id_use_sr2),
        .id_dest     (id_dest),
        .id_regwrite (id_regwrite),
        .id_is_load  (id_is_load),
        .mem_resp    (mem_resp),
        .mem_busy    (mem_busy),
        .opA_sel     (opA_sel),
        .opB_sel     (opB_sel),
        .opA_src     (opA_src),
        .opB_src     (opB_src),
        .stall       (stall),
        .bubble      (bubble),
        .dbg         (dbg)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic dec(input logic v, input logic [2:0] s1, input logic u1,
                       input logic [2:0] s2, input logic u2, input logic [2:0] d,
                       input logic rw, input logic ld);
        id_valid    = v;
        id_sr1      = s1;
        id_use_sr1  = u1;
        id_sr2      = s2;
        id_use_sr2  = u2;
        id_dest     = d;
        id_regwrite = rw;
        id_is_load  = ld;
    endtask

    task automatic nop();
        dec(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic mem(input logic busy, input logic resp);
        mem_busy = busy;
        mem_resp = resp;
    endtask

    task automatic expect_cycle(input string tag, input logic st, input logic bu);
        check({tag, ".stall"}, {7'd0, stall}, {7'd0, st});
        check({tag, ".bubble"}, {7'd0, bubble}, {7'd0, bu});
    endtask

    task automatic expect_fwd(input string tag, input logic as, input logic ac,
                              input logic bs, input logic bc);
        check({tag, ".opA_sel"}, {7'd0, opA_sel}, {7'd0, as});
        check({tag, ".opA_src"}, {7'd0, opA_src}, {7'd0, ac});
        check({tag, ".opB_sel"}, {7'd0, opB_sel}, {7'd0, bs});
        check({tag, ".opB_src"}, {7'd0, opB_src}, {7'd0, bc});
    endtask

    task automatic expect_state(input string tag, input fwd_state_t st);
        check({tag, ".state"}, 8'(dbg.state), 8'(st));
    endtask

    // Idle cycles so the shadow records hold nothing valid.
    task automatic flush();
        nop();
        mem(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick();
    endtask

    initial begin
        rst = 1'b1;
        nop();
        mem(1'b0, 1'b0);
        tick();
        tick();
        settle();
        expect_cycle("reset", 1'b0, 1'b0);
        expect_fwd("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        expect_state("reset", ST_RUN);
        check("reset.wait_cnt", dut.wait_cnt, 8'd0);
        rst = 1'b0;
        tick();

        // ADD R1 ; ADD R2,R1,R1 -> both operands from MEM.
        dec(1, 0, 1, 0, 1, 1, 1, 0); settle(); expect_cycle("a0", 0, 0); tick();
        dec(1, 1, 1, 1, 1, 2, 1, 0); settle(); expect_cycle("a1", 0, 0); tick();
        nop(); settle(); expect_fwd("a2", 1, FWD_MEM, 1, FWD_MEM); expect_cycle("a2", 0, 0); tick();
        flush();

        // ADD R1 ; ADD R1 ; ADD R3,R1,R2 -> youngest producer (src MEM).
        dec(1, 0, 1, 0, 1, 1, 1, 0); tick();
        dec(1, 0, 1, 0, 1, 1, 1, 0); tick();
        dec(1, 1, 1, 2, 1, 3, 1, 0); settle(); expect_cycle("p0", 0, 0); tick();
        nop(); settle(); expect_fwd("p1", 1, FWD_MEM, 0, FWD_MEM); tick();
        flush();

        // ADD R3 ; ADD R7,R6,#1 ; AND R4,R3,#5
        dec(1, 0, 1, 0, 0, 3, 1, 0); settle(); expect_cycle("b0", 0, 0); tick();
        dec(1, 6, 1, 0, 0, 7, 1, 0); settle(); expect_cycle("b1", 0, 0); tick();
        dec(1, 3, 1, 0, 0, 4, 1, 0); settle();
`ifdef EXE_WB_FWD_EN
        expect_cycle("b2", 0, 0); tick();
        nop(); settle(); expect_fwd("b3", 1, FWD_WB, 0, FWD_MEM); expect_cycle("b3", 0, 0); tick();
`else
        expect_cycle("b2", 1, 1); tick();
        settle(); expect_cycle("b3", 0, 0); expect_fwd("b3", 0, 0, 0, 0); tick();
        nop(); settle(); expect_fwd("b4", 0, 0, 0, 0); tick();
`endif
        flush();

        // LDR R5 ; ADD R6,R5,R2 -> one bubble, then forward.
        dec(1, 0, 1, 0, 0, 5, 1, 1); settle(); expect_cycle("c0", 0, 0); tick();
        dec(1, 5, 1, 2, 1, 6, 1, 0); settle(); expect_cycle("c1", 1, 1); tick();
        settle(); expect_state("c2", ST_LDUSE); expect_fwd("c2", 0, 0, 0, 0);
`ifdef EXE_WB_FWD_EN
        expect_cycle("c2", 0, 0); tick();
        nop(); settle(); expect_fwd("c3", 1, FWD_WB, 0, FWD_MEM); expect_cycle("c3", 0, 0);
        expect_state("c3", ST_RUN); tick();
`else
        expect_cycle("c2", 1, 1); tick();
        settle(); expect_cycle("c3", 0, 0); tick();
        nop(); settle(); expect_fwd("c4", 0, 0, 0, 0); tick();
`endif
        flush();

        // Invalid decode never matches or stalls.
        dec(1, 0, 1, 0, 1, 1, 1, 0); tick();
        dec(0, 1, 1, 1, 1, 2, 1, 0); settle(); expect_cycle("d1", 0, 0); tick();
        nop(); settle(); expect_fwd("d2", 0, 0, 0, 0); tick();
        dec(1, 0, 1, 0, 0, 5, 1, 1); tick();
        dec(0, 5, 1, 5, 1, 6, 1, 0); settle(); expect_cycle("d4", 0, 0); tick();
        flush();

        // Response in the same cycle as busy: no stall.
        mem(1, 1); settle(); expect_cycle("e0", 0, 0); tick();
        mem(0, 0); settle(); expect_state("e1", ST_RUN); tick();

        // Four wait cycles; selects hold through the wait.
        dec(1, 0, 1, 0, 1, 1, 1, 0); tick();
        dec(1, 1, 1, 1, 1, 2, 1, 0); tick();
        nop(); mem(1, 0); settle(); expect_cycle("f0", 1, 0); expect_fwd("f0", 1, 0, 1, 0); tick();
        for (int i = 1; i < 4; i++) begin
            settle();
            expect_cycle($sformatf("f%0d", i), 1, 0);
            expect_state($sformatf("f%0d", i), ST_MEMWAIT);
            expect_fwd($sformatf("f%0d", i), 1, 0, 1, 0);
            tick();
        end
        mem(1, 1); settle(); expect_cycle("f4", 0, 0); expect_state("f4", ST_MEMWAIT); tick();
        mem(0, 0); settle(); expect_state("f5", ST_RUN); expect_cycle("f5", 0, 0);
        check("f5.wait_cnt", dut.wait_cnt, 8'd4);
        expect_fwd("f5", 0, 0, 0, 0); tick();
        flush();

        // Load-use coincident with a memory wait.
        dec(1, 0, 1, 0, 0, 5, 1, 1); tick();
        dec(1, 5, 1, 2, 1, 6, 1, 0); mem(1, 0); settle(); expect_cycle("g1", 1, 0); tick();
        settle(); expect_cycle("g2", 1, 0); expect_state("g2", ST_MEMWAIT); tick();
        mem(1, 1); settle(); expect_cycle("g3", 1, 1); expect_state("g3", ST_MEMWAIT); tick();
        mem(0, 0); settle(); expect_state("g4", ST_LDUSE); check("g4.wait_cnt", dut.wait_cnt, 8'd2);
`ifdef EXE_WB_FWD_EN
        expect_cycle("g4", 0, 0); tick();
        nop(); settle(); expect_fwd("g5", 1, FWD_WB, 0, FWD_MEM); expect_cycle("g5", 0, 0); tick();
`else
        expect_cycle("g4", 1, 1); tick();
        settle(); expect_cycle("g5", 0, 0); tick();
        nop(); tick();
`endif
        flush();

        // Reset during MEMWAIT discards the in-flight ADD R1.
        dec(1, 0, 1, 0, 1, 1, 1, 0); tick();
        nop(); mem(1, 0); settle(); expect_cycle("h1", 1, 0); tick();
        settle(); expect_state("h2", ST_MEMWAIT); rst = 1'b1; tick();
        rst = 1'b0; mem(0, 0); dec(1, 1, 1, 1, 1, 2, 1, 0); settle();
        expect_cycle("h3", 0, 0); expect_fwd("h3", 0, 0, 0, 0); expect_state("h3", ST_RUN);
        check("h3.wait_cnt", dut.wait_cnt, 8'd0); tick();
        dec(1, 0, 1, 0, 1, 1, 1, 0); settle(); expect_fwd("h4", 0, 0, 0, 0); tick();
        dec(1, 1, 1, 1, 1, 3, 1, 0); settle(); expect_cycle("h5", 0, 0); tick();
        nop(); settle(); expect_fwd("h6", 1, FWD_MEM, 1, FWD_MEM); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exe_fwd_ctrl.md
EXE_FWD_CTRL -- requirements
Module: exe_fwd_ctrl

Interface
REQ-001 clk  in  1  rising-edge clock, single clock domain.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 id_valid  in  1  instruction present in decode.
REQ-004 id_sr1 / id_sr2  in  3 each  decode source register numbers.
REQ-005 id_use_sr1 / id_use_sr2  in  1 each  source actually read; sr2 is 0 when the immediate/SEXT path is used.
REQ-006 id_dest  in  3  decode destination register.
REQ-007 id_regwrite  in  1  decode instruction writes id_dest.
REQ-008 id_is_load  in  1  decode instruction is a load (LDR/LDB/LDI).
REQ-009 mem_resp  in  1  data memory completes the access in MEM this cycle.
REQ-010 mem_busy  in  1  MEM stage holds a memory access.
REQ-011 opA_sel / opB_sel  out  1 each  EXE operand mux select, 1 = forwarded value.
REQ-012 opA_src / opB_src  out  1 each  forward source, 0 = MEM result, 1 = WB result.
REQ-013 stall  out  1  hold fetch/decode/EX pipeline registers.
REQ-014 bubble  out  1  load a NOP into EX at the next edge.

Function
REQ-015 Tracks shadow records {valid, dest, regwrite, is_load} for EX, MEM and WB; the records advance one stage per cycle when stall=0.
REQ-016 When bubble=1, the EX record loads valid=0; when stall=1 and bubble=0, all records hold.
REQ-017 Forwarding is registered: opX_sel/opX_src are computed from decode fields and valid during cycle N, and apply to the EX instruction during cycle N+1.
REQ-018 Source match requires id_use_srX=1, a producer record with valid=1 and regwrite=1, and an equal register number; R0 has no special case.
REQ-019 Priority is the youngest producer first: EX record (arrives as MEM at use time, src=0), then MEM record (arrives as WB, src=1); with no match, sel=0.
REQ-020 Load-use: the EX record is a valid load whose dest matches a used decode source -> FSM enters LDUSE, stall=1 and bubble=1 for exactly 1 cycle, then forwarding proceeds from WB (src=1).
REQ-021 FSM states: RUN, LDUSE, MEMWAIT. RUN->LDUSE on a load-use hazard. RUN->MEMWAIT when mem_busy=1 and mem_resp=0. LDUSE->RUN after 1 cycle. MEMWAIT->RUN in the cycle mem_resp=1.
REQ-022 In MEMWAIT, stall=1 and bubble=0, and forwarding outputs hold their values.
REQ-023 Simultaneous load-use and memory wait: MEMWAIT has priority; the hazard is re-evaluated on return to RUN.
REQ-024 A mem_resp=1 arriving in the same cycle as mem_busy=1 causes no stall.
REQ-025 id_valid=0 produces no hazard, sel=0 and no stall.
REQ-026 A wait counter (8-bit, saturating) counts MEMWAIT cycles; it clears on entry to MEMWAIT and is readable only in simulation.

Reset
REQ-027 On rst=1 at the clock edge, all records are invalid, FSM=RUN, stall=0, bubble=0, opA_sel=opB_sel=0, opA_src=opB_src=0, and the counter is 0.
REQ-028 Reset mid-MEMWAIT or mid-LDUSE returns to RUN next cycle; the in-flight records are discarded.

Configuration
REQ-029 With macro EXE_WB_FWD_EN defined, forwarding from WB (src=1) is enabled as described above.
REQ-030 Without EXE_WB_FWD_EN, a match against the MEM record asserts stall=1 and bubble=1 for one cycle instead of forwarding; opX_src is then always 0.

Structure
REQ-031 The shared lc3b_types package holds the fwd_rec_t record typedef, the FSM state enum, and the constants FWD_MEM=0 and FWD_WB=1.
REQ-032 The comparator/priority logic is one sub-module, fwd_match, instantiated once per operand; the FSM and records stay in the top level.

Verification
REQ-033 ADD R1 then ADD R2,R1,R1 back-to-back -> next cycle opA_sel=opB_sel=1 and opA_src=opB_src=0, no stall.
REQ-034 ADD R3, an unrelated instruction, then AND R4,R3,#5 -> opA_sel=1 with src=1, opB_sel=0 (immediate).
REQ-035 LDR R5 followed by ADD R6,R5,R2 -> stall=1 and bubble=1 for 1 cycle, then opA_sel=1 with src=1.
REQ-036 mem_busy=1 with mem_resp low for 4 cycles -> stall=1 for 4 cycles, bubble=0, and the counter reads 4.
REQ-037 Load-use hazard coincident with mem_busy -> MEMWAIT first; after mem_resp, exactly one LDUSE bubble.
REQ-038 rst asserted during MEMWAIT -> next cycle stall=0 and all selects are 0; an ADD R1 then ADD R1 sequence forwards correctly afterward.
